// File: rtl/fifo_wr_ctrl.sv
// Write-side burst controller for the asynchronous FIFO: accepts burst descriptors,
// negotiates the write grant with fifo_ack and streams words into the dual-port memory.
module fifo_wr_ctrl #(
    parameter int ADDRSIZE = 10,
    parameter int DATASIZE = 8
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDRSIZE:0]   req_len,
    input  logic [1:0]          req_idle,
    input  logic [DATASIZE-1:0] din,
    output logic                din_rdy,
    input  logic                wack,
    input  logic                wfull,
    output logic                wen,
    output logic [1:0]          widle,
    output logic                winc,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [DATASIZE-1:0] wdata,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE:0]   wgray,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WRITE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDRSIZE:0] ONE_W = {{ADDRSIZE{1'b0}}, 1'b1};

    function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    state_t              state_q, state_d;
    logic [ADDRSIZE:0]   remaining_q, remaining_d;
    logic [1:0]          widle_q, widle_d;
    logic [1:0]          gap_q, gap_d;
    logic [ADDRSIZE:0]   wptr_q, wptr_d;
    logic [ADDRSIZE:0]   wgray_q;
    logic                write_s;
    logic                req_ready_s;
    logic                wen_s;
    logic                busy_s;
    logic                done_s;

    // State register and write pointers; reset abandons any burst in flight.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            widle_q     <= 2'd0;
            gap_q       <= 2'd0;
            wptr_q      <= '0;
            wgray_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            widle_q     <= widle_d;
            gap_q       <= gap_d;
            wptr_q      <= wptr_d;
            wgray_q     <= bin2gray(wptr_d);
        end
    end

    // Next-state and output decode; a write needs the grant and a non-full FIFO.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        widle_d     = widle_q;
        gap_d       = gap_q;
        wptr_d      = wptr_q;
        write_s     = 1'b0;
        req_ready_s = 1'b0;
        wen_s       = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid) begin
                    remaining_d = (req_len == '0) ? ONE_W : req_len;
                    widle_d     = req_idle;
                    state_d     = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                wen_s  = 1'b1;
                busy_s = 1'b1;
                if (wack) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WRITE: begin
                wen_s  = 1'b1;
                busy_s = 1'b1;
                if (wack && !wfull) begin
                    write_s     = 1'b1;
                    remaining_d = remaining_q - ONE_W;
                    wptr_d      = wptr_q + ONE_W;
                    if (remaining_q == ONE_W) begin
                        state_d = ST_DONE;
                    end else if (widle_q == 2'd0) begin
                        state_d = ST_WRITE;
                    end else begin
                        gap_d   = widle_q - 2'd1;
                        state_d = ST_GAP;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_GAP: begin
                wen_s  = 1'b1;
                busy_s = 1'b1;
                if (gap_q == 2'd0) begin
                    state_d = ST_WRITE;
                end else begin
                    gap_d   = gap_q - 2'd1;
                    state_d = ST_GAP;
                end
            end
            ST_DONE: begin
                done_s  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready = req_ready_s;
    assign wen       = wen_s;
    assign busy      = busy_s;
    assign done      = done_s;
    assign winc      = write_s;
    assign din_rdy   = write_s;
    assign wdata     = write_s ? din : '0;
    assign waddr     = wptr_q[ADDRSIZE-1:0];
    assign wptr      = wptr_q;
    assign wgray     = wgray_q;
    assign widle     = widle_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: bursts queue their expected writes, a negedge
// monitor pops and compares every memory write against the queued reference.
module tb_fifo_wr_ctrl;

    logic        wclk = 1'b0;
    logic        wrst;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_len;
    logic [1:0]  req_idle;
    logic [7:0]  din;
    logic        din_rdy;
    logic        wack;
    logic        wfull;
    logic        wen;
    logic [1:0]  widle;
    logic        winc;
    logic [9:0]  waddr;
    logic [7:0]  wdata;
    logic [10:0] wptr;
    logic [10:0] wgray;
    logic        busy;
    logic        done;

    fifo_wr_ctrl #(.ADDRSIZE(10), .DATASIZE(8)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_ready(req_ready),
        .req_len(req_len), .req_idle(req_idle), .din(din), .din_rdy(din_rdy),
        .wack(wack), .wfull(wfull), .wen(wen), .widle(widle), .winc(winc),
        .waddr(waddr), .wdata(wdata), .wptr(wptr), .wgray(wgray),
        .busy(busy), .done(done)
    );

    always #5 wclk = ~wclk;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
        logic       first;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  prod_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    logic [10:0] mptr = 11'd0;
    logic [10:0] base = 11'd0;
    logic [1:0]  cur_idle = 2'd0;
    bit          exact = 1'b0;
    bit          mon_en = 1'b0;
    int          cyc = 0;
    int          last_w = 0;

    task automatic chk(input bit ok, input string nm, input int act, input int expv);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    // Monitor: per-cycle pointer tracking and scoreboard pop on every write.
    initial begin
        din = 8'h00;
        forever begin
            @(negedge wclk);
            cyc++;
            if (wrst) begin
                exp_q.delete();
                prod_q.delete();
                mptr = 11'd0;
            end else if (mon_en) begin
                chk(wptr == mptr, "wptr", int'(wptr), int'(mptr));
                chk(wgray == (mptr ^ (mptr >> 1)), "wgray", int'(wgray), int'(mptr ^ (mptr >> 1)));
                if (winc) begin
                    chk(wack && !wfull, "write_while_stalled", int'(winc), 0);
                    chk(din_rdy == 1'b1, "din_rdy_on_write", int'(din_rdy), 1);
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_winc", int'(waddr), -1);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk(waddr == e.addr, "waddr", int'(waddr), int'(e.addr));
                        chk(wdata == e.data, "wdata", int'(wdata), int'(e.data));
                        if (exact && !e.first)
                            chk(cyc - last_w == int'(cur_idle) + 1, "spacing", cyc - last_w, int'(cur_idle) + 1);
                        last_w = cyc;
                        mptr = mptr + 11'd1;
                        if (prod_q.size() > 0) void'(prod_q.pop_front());
                    end
                end else if (din_rdy) begin
                    chk(1'b0, "din_rdy_without_winc", 1, 0);
                end
                if (wen) chk(widle == cur_idle, "widle", int'(widle), int'(cur_idle));
                if (done) begin
                    chk(exp_q.size() == 0, "done_early", exp_q.size(), 0);
                    chk(req_ready == 1'b0 && wen == 1'b0, "done_cycle_ready_wen", int'({req_ready, wen}), 0);
                    done_cnt++;
                end
            end
            din = (prod_q.size() > 0) ? prod_q[0] : 8'h00;
        end
    end

    task automatic issue(input int len, input int idle);
        int k;
        int n;
        @(posedge wclk); #1;
        k = 0;
        while (!req_ready && k < 200) begin
            @(posedge wclk); #1;
            k++;
        end
        chk(req_ready == 1'b1, "req_ready_timeout", int'(req_ready), 1);
        n = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.addr  = 10'(base + 11'(i));
            e.data  = 8'($urandom_range(0, 255));
            e.first = (i == 0);
            exp_q.push_back(e);
            prod_q.push_back(e.data);
        end
        base      = base + 11'(n);
        cur_idle  = 2'(idle);
        req_len   = 11'(len);
        req_idle  = 2'(idle);
        req_valid = 1'b1;
        @(negedge wclk);
        chk(wen == 1'b0, "wen_at_accept", int'(wen), 0);
        @(posedge wclk); #1;
        req_valid = 1'b0;
        @(negedge wclk);
        chk(wen == 1'b1, "wen_latency", int'(wen), 1);
    endtask

    task automatic wait_done(input bit rnd);
        int tgt;
        int k;
        tgt = done_cnt + 1;
        k = 0;
        while (done_cnt < tgt && k < 5000) begin
            @(posedge wclk); #1;
            if (rnd) begin
                wack  = ($urandom_range(0, 3) != 0);
                wfull = ($urandom_range(0, 4) == 0);
            end
            k++;
        end
        chk(done_cnt >= tgt, "done_timeout", done_cnt, tgt);
        wack  = 1'b1;
        wfull = 1'b0;
        @(posedge wclk); #1;
        chk(req_ready == 1'b1 && done_cnt == tgt, "done_once_ready", done_cnt, tgt);
    endtask

    task automatic wait_ptr(input logic [10:0] target);
        int k;
        k = 0;
        while (mptr != target && k < 500) begin
            @(posedge wclk); #1;
            k++;
        end
        chk(mptr == target, "ptr_wait_timeout", int'(mptr), int'(target));
    endtask

    initial begin
        logic [10:0] start;
        int          dc;
        wrst = 1'b1; req_valid = 1'b0; req_len = 11'd0; req_idle = 2'd0;
        wack = 1'b1; wfull = 1'b0;
        repeat (2) @(posedge wclk);
        #1 wrst = 1'b0;
        @(negedge wclk);
        chk(wptr == 11'd0 && wgray == 11'd0, "reset_ptrs", int'(wptr), 0);
        chk(wen == 1'b0 && winc == 1'b0 && busy == 1'b0 && done == 1'b0, "reset_ctl", int'({wen, winc, busy, done}), 0);
        chk(req_ready == 1'b1, "reset_req_ready", int'(req_ready), 1);
        chk(widle == 2'd0 && wdata == 8'd0, "reset_widle_wdata", int'(widle), 0);
        mon_en = 1'b1;

        exact = 1'b1;
        issue(4, 0);
        wait_done(1'b0);
        chk(wptr == 11'd4 && wgray == 11'd6, "len4_final", int'(wgray), 6);

        issue(3, 2);
        wait_done(1'b0);
        chk(wptr == 11'd7, "len3_idle2_final", int'(wptr), 7);

        exact = 1'b0;
        wack  = 1'b0;
        issue(2, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge wclk);
            chk(wen == 1'b1 && winc == 1'b0, "wack_low_hold", int'({wen, winc}), 2);
        end
        @(posedge wclk); #1;
        wack = 1'b1;
        @(negedge wclk);
        chk(winc == 1'b0, "wack_rise_same_cycle", int'(winc), 0);
        @(negedge wclk);
        chk(winc == 1'b1, "first_write_after_wack", int'(winc), 1);
        wait_done(1'b0);
        chk(wptr == 11'd9, "wack_burst_final", int'(wptr), 9);

        start = wptr;
        issue(5, 0);
        wait_ptr(start + 11'd2);
        wfull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge wclk);
            chk(winc == 1'b0 && din_rdy == 1'b0 && wen == 1'b1, "wfull_stall", int'({winc, din_rdy, wen}), 1);
            @(posedge wclk); #1;
        end
        wfull = 1'b0;
        wait_done(1'b0);
        chk(wptr == start + 11'd5, "wfull_final", int'(wptr), int'(start + 11'd5));

        exact = 1'b1;
        start = wptr;
        issue(0, 3);
        wait_done(1'b0);
        chk(wptr == start + 11'd1, "len0_is_one", int'(wptr), int'(start + 11'd1));

        exact = 1'b0;
        for (int b = 0; b < 8; b++) begin
            issue($urandom_range(0, 20), $urandom_range(0, 3));
            wait_done(1'b1);
        end

        start = wptr;
        issue(8, 0);
        wait_ptr(start + 11'd2);
        dc = done_cnt;
        wrst = 1'b1;
        @(posedge wclk); #1;
        wrst = 1'b0;
        base = 11'd0;
        @(negedge wclk);
        chk(wen == 1'b0 && busy == 1'b0 && winc == 1'b0, "midreset_ctl", int'({wen, busy, winc}), 0);
        chk(wptr == 11'd0, "midreset_wptr", int'(wptr), 0);
        repeat (5) @(negedge wclk);
        chk(done_cnt == dc, "midreset_no_done", done_cnt, dc);

        exact = 1'b1;
        issue(1024, 0);
        wait_done(1'b0);
        chk(wptr == 11'd1024 && wgray == 11'h600, "full_burst_gray", int'(wgray), 1536);
        issue(1022, 0);
        wait_done(1'b0);
        chk(wptr == 11'd2046, "preload_2046", int'(wptr), 2046);
        issue(4, 0);
        wait_done(1'b0);
        chk(wptr == 11'd2 && wgray == 11'd3, "wrap_final", int'(wptr), 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side burst controller sitting directly upstream of fifo_ack in the asynchronous FIFO.
- Accepts a burst descriptor from the producer: length plus idle-cycle code.
- Raises wen and holds it until fifo_ack grants wack.
- Streams the burst into the dual-port memory, spacing words by the programmed idle count.
- Maintains the binary and Gray write pointers that fifo_ack and the read-side synchroniser consume.

Parameters:
ADDRSIZE, 10, memory address width (depth = 2**ADDRSIZE = 1024)
DATASIZE, 8, data word width

Ports:
wclk  input  1  write-domain clock
wrst  input  1  synchronous, active-high reset
req_valid  input  1  burst descriptor valid
req_ready  output  1  controller can accept a descriptor
req_len  input  ADDRSIZE+1  burst length in words, 1..1024; 0 is treated as 1
req_idle  input  2  idle cycles between consecutive writes (0..3)
din  input  DATASIZE  producer data; must be valid while din_rdy=1
din_rdy  output  1  word consumed this cycle
wack  input  1  write grant from fifo_ack
wfull  input  1  FIFO full flag from fifo_ack
wen  output  1  write request to fifo_ack
widle  output  2  registered req_idle for the active burst; fed to fifo_ack
winc  output  1  memory write strobe
waddr  output  ADDRSIZE  memory write address (wptr[ADDRSIZE-1:0])
wdata  output  DATASIZE  memory write data
wptr  output  ADDRSIZE+1  binary write pointer, including the wrap bit
wgray  output  ADDRSIZE+1  Gray-coded write pointer (wptr ^ (wptr>>1)), registered
busy  output  1  burst in progress
done  output  1  one-cycle pulse after the last word of a burst is written

Behaviour:
Reset (wrst=1 at a wclk edge):
- State goes to IDLE.
- wptr, wgray, widle, wen, winc, din_rdy, busy and done are all 0; wdata is 0.
- req_ready is 1 once wrst drops.
- Reset mid-burst abandons the burst: the remaining count is cleared and no further writes occur.

FSM states: IDLE, REQ, WRITE, GAP, DONE.
- IDLE
  - req_ready=1.
  - On req_valid: latch len (0 is forced to 1) into remaining and req_idle into widle, then go to REQ.
- REQ
  - wen=1, busy=1.
  - Stay until wack=1 is sampled, then go to WRITE. No timeout.
- WRITE
  - If wfull=0:
    - Assert din_rdy and winc for one cycle, with wdata=din and waddr=wptr[ADDRSIZE-1:0].
    - The wptr and wgray increments are visible on the next cycle.
    - Decrement remaining.
  - If wfull=1: stall with winc=0 and din_rdy=0, holding state. wen stays 1 during the stall.
  - Next state after a write:
    - remaining==0 → DONE.
    - Otherwise widle==0 → WRITE.
    - Otherwise → GAP.
- GAP
  - Count widle cycles with winc=0, then return to WRITE.
  - Back-to-back write spacing is widle+1 cycles.
- DONE
  - done=1 for one cycle; wen drops; return to IDLE.
  - req_ready is 0 in this cycle.

wen rules:
- wen stays 1 from REQ entry through the final write.
- If wack falls during WRITE/GAP, the burst pauses before the next write and holds wen=1 until wack returns. This makes fifo_ack re-grant.

Arithmetic:
- wptr is ADDRSIZE+1 bits and wraps 2047→0 with no special handling.
- The wrap bit toggles every 1024 writes.
- wgray is registered from the next-state binary value, so wgray always matches wptr in the same cycle.

Boundary and priority cases:
- wfull and wack asserted in the same cycle: no write.
- A 1024-word burst starting at wptr=0 ends at wptr=1024 with wgray=0x600.
- req_valid while busy is ignored; the producer must hold it.

Latency: req_valid accepted → wen at +1 cycle; wack sampled → first winc at +1 cycle.

Test Plan:
- Reset then idle: wrst high for 2 cycles → wptr=0, wgray=0, wen=0, winc=0, req_ready=1.
- req_len=4, req_idle=0, wack tied 1 →
  - wen rises 1 cycle after accept.
  - 4 consecutive winc pulses at waddr 0,1,2,3; wptr=4, wgray=6.
  - done pulses once; req_ready returns 1.
- req_len=3, req_idle=2 → winc pulses spaced 3 cycles apart; widle=2 throughout the burst.
- wack held 0 for 10 cycles after request → wen=1 for all 10 cycles, no winc; first write 1 cycle after wack rises.
- wfull raised after 2nd word of a 5-word burst for 4 cycles →
  - no winc or din_rdy during the stall; wen stays 1.
  - writes resume; final wptr=5.
- Wrap: preload via bursts to wptr=2046, then a 4-word burst → waddr 1022,1023,0,1; wptr sequence 2047,0,1,2; wgray correct at each step.
- Reset mid-burst at word 3 of 8 → next cycle wen=0, busy=0, wptr=0, no done pulse.
